// File: rtl/madcalc_pkg.sv
// Shared definitions for the median/MAD calculator and its downstream Hampel flagger:
// the flagger FSM state set, the fixed-point format and the threshold width.
package madcalc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_e;

    // Number of fractional bits in the Q8.8 scale factor and threshold.
    localparam int Q_FRAC_BITS = 8;

    // Default MAD-to-sigma factor, 1.4826 in unsigned Q8.8.
    localparam logic [15:0] DEF_SCALE_FACTOR = 16'h017C;

    // 16-bit MAD x 16-bit scale factor x 4-bit multiplier, kept at full width.
    localparam int THR_WIDTH = 36;

endpackage

// File: rtl/hampel_thresh.sv
// Registered Hampel threshold: thr = MAD * SCALE_FACTOR * THRESH_K in Q8.8.
// The constant part (SCALE_FACTOR * THRESH_K) folds at elaboration, so only a
// single 16 x 20 multiply remains; the product is captured while load_i is high.
module hampel_thresh
    import madcalc_pkg::*;
#(
    parameter logic [15:0] SCALE_FACTOR = DEF_SCALE_FACTOR,
    parameter int          THRESH_K     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [15:0]          mad_i,
    output logic [THR_WIDTH-1:0] thr_o
);

    localparam logic [19:0] SCALE_K = 20'(SCALE_FACTOR) * 20'(THRESH_K);

    logic [THR_WIDTH-1:0] thr_q;

    // Capture the full-width product whenever new stats are being loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= '0;
        end else if (load_i) begin
            thr_q <= THR_WIDTH'(mad_i) * THR_WIDTH'(SCALE_K);
        end
    end

    assign thr_o = thr_q;

endmodule

// File: rtl/hampel_flagger.sv
// Hampel outlier flagger. On a stats_vld pulse it latches median and MAD, builds
// the threshold, re-reads the whole window from the sample buffer and streams each
// sample out with an outlier flag and a running outlier count.
// Optional feature macro: HAMPEL_REPLACE_EN -- when defined, flagged samples are
// emitted as the median instead of the raw value.
module hampel_flagger
    import madcalc_pkg::*;
#(
    parameter int          POPSIZE      = 100,
    parameter int          DATA_WIDTH   = 8,
    parameter logic [15:0] SCALE_FACTOR = DEF_SCALE_FACTOR,
    parameter int          THRESH_K     = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stats_vld,
    input  logic [15:0]                    local_median,
    input  logic [15:0]                    MAD,
    output logic                           rd_rqst,
    output logic [$clog2(POPSIZE)-1:0]     addr_out,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           data_rdy,
    output logic [DATA_WIDTH-1:0]          sample_out,
    output logic [$clog2(POPSIZE)-1:0]     sample_idx,
    output logic                           outlier_flag,
    output logic                           sample_vld,
    input  logic                           out_rdy,
    output logic                           done,
    output logic [$clog2(POPSIZE+1)-1:0]   outlier_cnt
);

    localparam int AW = $clog2(POPSIZE);
    localparam int CW = $clog2(POPSIZE + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(POPSIZE - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] median_q;
    logic [15:0]           mad_q;
    logic                  pend_vld_q;
    logic [DATA_WIDTH-1:0] pend_median_q;
    logic [15:0]           pend_mad_q;
    logic                  rd_rqst_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] sample_out_q;
    logic [AW-1:0]         sample_idx_q;
    logic                  flag_q;
    logic                  vld_q;
    logic                  done_q;
    logic [CW-1:0]         cnt_q;

    logic [THR_WIDTH-1:0]  thr;
    logic [DATA_WIDTH-1:0] dev_d;
    logic [THR_WIDTH-1:0]  dev_scaled_d;
    logic                  is_outlier_d;
    logic [DATA_WIDTH-1:0] emit_sample_d;

    // Only the low DATA_WIDTH bits of the median are meaningful.
    if (DATA_WIDTH < 16) begin : g_unused_median
        logic unused_median_bits;
        assign unused_median_bits = ^local_median[15:DATA_WIDTH];
    end

    hampel_thresh #(
        .SCALE_FACTOR (SCALE_FACTOR),
        .THRESH_K     (THRESH_K)
    ) u_thresh (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == ST_LOAD),
        .mad_i  (mad_q),
        .thr_o  (thr)
    );

    // Deviation from the median, aligned to Q8.8 and compared strictly against the threshold.
    always_comb begin
        dev_d         = (data_in >= median_q) ? (data_in - median_q) : (median_q - data_in);
        dev_scaled_d  = THR_WIDTH'({dev_d, {Q_FRAC_BITS{1'b0}}});
        is_outlier_d  = dev_scaled_d > thr;
`ifdef HAMPEL_REPLACE_EN
        emit_sample_d = is_outlier_d ? median_q : data_in;
`else
        emit_sample_d = data_in;
`endif
    end

    // Scan FSM: load stats, then request / wait / emit each sample, then pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            median_q      <= '0;
            mad_q         <= '0;
            pend_vld_q    <= 1'b0;
            pend_median_q <= '0;
            pend_mad_q    <= '0;
            rd_rqst_q     <= 1'b0;
            addr_q        <= '0;
            sample_out_q  <= '0;
            sample_idx_q  <= '0;
            flag_q        <= 1'b0;
            vld_q         <= 1'b0;
            done_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // Stats arriving mid-scan are parked; the newest one wins.
            if (stats_vld && state_q != ST_IDLE) begin
                pend_vld_q    <= 1'b1;
                pend_median_q <= local_median[DATA_WIDTH-1:0];
                pend_mad_q    <= MAD;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pend_vld_q) begin
                        // A parked request starts first; a coincident pulse is parked behind it.
                        median_q   <= pend_median_q;
                        mad_q      <= pend_mad_q;
                        pend_vld_q <= stats_vld;
                        if (stats_vld) begin
                            pend_median_q <= local_median[DATA_WIDTH-1:0];
                            pend_mad_q    <= MAD;
                        end
                        state_q <= ST_LOAD;
                    end else if (stats_vld) begin
                        median_q <= local_median[DATA_WIDTH-1:0];
                        mad_q    <= MAD;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    addr_q    <= '0;
                    cnt_q     <= '0;
                    rd_rqst_q <= 1'b1;
                    state_q   <= ST_REQ;
                end
                ST_REQ: begin
                    rd_rqst_q <= 1'b0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        sample_out_q <= emit_sample_d;
                        sample_idx_q <= addr_q;
                        flag_q       <= is_outlier_d;
                        vld_q        <= 1'b1;
                        state_q      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_rdy) begin
                        vld_q <= 1'b0;
                        if (flag_q) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                        if (addr_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            addr_q    <= addr_q + AW'(1);
                            rd_rqst_q <= 1'b1;
                            state_q   <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_rqst      = rd_rqst_q;
    assign addr_out     = addr_q;
    assign sample_out   = sample_out_q;
    assign sample_idx   = sample_idx_q;
    assign outlier_flag = flag_q;
    assign sample_vld   = vld_q;
    assign done         = done_q;
    assign outlier_cnt  = cnt_q;

endmodule

// File: tb/tb_hampel_flagger.sv
// Self-checking bench for hampel_flagger: directed scenarios plus randomized windows,
// checked against a window-level Hampel model (|x - median| * 256 > MAD * SF * K).
module tb_hampel_flagger;

    localparam int          P  = 4;
    localparam int          DW = 8;
    localparam int          AW = $clog2(P);
    localparam int          CW = $clog2(P + 1);
    localparam logic [15:0] SF = 16'h017C;
    localparam int          K  = 3;

    logic          clk;
    logic          rst_n;
    logic          stats_vld;
    logic [15:0]   local_median;
    logic [15:0]   MAD;
    logic          rd_rqst;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_in;
    logic          data_rdy;
    logic [DW-1:0] sample_out;
    logic [AW-1:0] sample_idx;
    logic          outlier_flag;
    logic          sample_vld;
    logic          out_rdy;
    logic          done;
    logic [CW-1:0] outlier_cnt;

    hampel_flagger #(
        .POPSIZE      (P),
        .DATA_WIDTH   (DW),
        .SCALE_FACTOR (SF),
        .THRESH_K     (K)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stats_vld    (stats_vld),
        .local_median (local_median),
        .MAD          (MAD),
        .rd_rqst      (rd_rqst),
        .addr_out     (addr_out),
        .data_in      (data_in),
        .data_rdy     (data_rdy),
        .sample_out   (sample_out),
        .sample_idx   (sample_idx),
        .outlier_flag (outlier_flag),
        .sample_vld   (sample_vld),
        .out_rdy      (out_rdy),
        .done         (done),
        .outlier_cnt  (outlier_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Sample buffer and environment knobs.
    logic [DW-1:0] mem [P];
    int  lat = 1;
    int  rdy_mode = 0;
    int  stall_left = 0;
    bit  spur_en = 0;
    bit  abort_mode = 0;
    bit  rq_armed = 0;
    int  first_rq_cyc = 0;
    int  first_rq_addr = -1;

    // Window-level model state.
    bit  busy = 0;
    bit  pend_v = 0;
    int  cur_med, cur_mad, pend_med, pend_mad;
    int  m_idx = 0;
    int  m_cnt = 0;
    int  done_seen = 0;
    int  done_cyc = 0;
    int  stats_cyc = 0;
    int  stall_checks = 0;
    int  cap_flag [P];
    int  cap_samp [P];
    int  cap_idx  [P];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_flag(input int s, input int m, input int mad);
        longint thr;
        longint dev;
        thr = longint'(mad) * longint'(SF) * longint'(K);
        dev = (s > m) ? longint'(s - m) : longint'(m - s);
        return (dev * 256) > thr;
    endfunction

    function automatic int model_out(input int s, input int m, input int mad);
`ifdef HAMPEL_REPLACE_EN
        return model_flag(s, m, mad) ? m : s;
`else
        return s + 0 * (m + mad);
`endif
    endfunction

    // Sample buffer: answers each rd_rqst after lat cycles, optionally injects stray data_rdy.
    initial begin
        int rcnt = -1;
        logic [AW-1:0] la = '0;
        data_rdy = 1'b0;
        data_in  = '0;
        forever begin
            @(negedge clk);
            data_rdy = 1'b0;
            if (rcnt > 0) begin
                if (rst_n && !abort_mode) chk("addr_stable", 64'(addr_out), 64'(la));
                rcnt--;
                if (rcnt == 0) begin
                    data_rdy = 1'b1;
                    data_in  = mem[la];
                    rcnt     = -1;
                end
            end else if (spur_en && !rd_rqst && $urandom_range(0, 7) == 0) begin
                data_rdy = 1'b1;
                data_in  = DW'($urandom);
            end
            if (rd_rqst) begin
                la   = addr_out;
                rcnt = lat;
                if (rq_armed) begin
                    first_rq_cyc  = cyc;
                    first_rq_addr = int'(addr_out);
                    rq_armed      = 0;
                end
            end
        end
    end

    // Consumer: always ready, random ready, or a fixed stall on the next emitted sample.
    initial begin
        out_rdy = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       out_rdy = ($urandom_range(0, 2) != 0);
                3: begin
                    if (sample_vld && stall_left > 0) begin
                        out_rdy = 1'b0;
                        stall_left--;
                    end else begin
                        out_rdy = 1'b1;
                    end
                end
                default: out_rdy = 1'b1;
            endcase
        end
    end

    // Compare process: checks every cycle's outputs against the model.
    initial begin
        bit            exp_done = 0;
        bit            prev_stall = 0;
        bit            hold_chk = 0;
        int            held_cnt = 0;
        logic [DW-1:0] ps = '0;
        logic          pf = 1'b0;
        logic [AW-1:0] pi = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_done   = 0;
                prev_stall = 0;
                hold_chk   = 0;
                continue;
            end
            if (prev_stall) begin
                stall_checks++;
                chk("stall_vld", 64'(sample_vld), 64'(1));
                chk("stall_sample", 64'(sample_out), 64'(ps));
                chk("stall_flag", 64'(outlier_flag), 64'(pf));
                chk("stall_idx", 64'(sample_idx), 64'(pi));
            end
            if (hold_chk) begin
                chk("cnt_hold", 64'(outlier_cnt), 64'(held_cnt));
                hold_chk = 0;
            end
            chk("done", 64'(done), 64'(exp_done));
            exp_done = 0;
            if (done) begin
                chk("cnt_at_done", 64'(outlier_cnt), 64'(m_cnt));
                done_seen++;
                done_cyc = cyc;
                hold_chk = 1;
                held_cnt = m_cnt;
                if (pend_v) begin
                    cur_med = pend_med;
                    cur_mad = pend_mad;
                    pend_v  = 0;
                    m_idx   = 0;
                    m_cnt   = 0;
                end else begin
                    busy = 0;
                end
            end
            if (sample_vld) begin
                chk("rqst_in_emit", 64'(rd_rqst), 64'(0));
                chk("cnt_mid", 64'(outlier_cnt), 64'(m_cnt));
                if (out_rdy) begin
                    if (!busy || m_idx >= P) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept: idx %0d sample %0d with no scan expected", sample_idx, sample_out);
                    end else begin
                        int s;
                        int f;
                        s = int'(mem[m_idx]);
                        f = int'(model_flag(s, cur_med, cur_mad));
                        $display("ACCEPT idx=%0d sample=%0d flag=%0d | expect idx=%0d sample=%0d flag=%0d",
                                 sample_idx, sample_out, outlier_flag, m_idx, model_out(s, cur_med, cur_mad), f);
                        chk("acc_idx", 64'(sample_idx), 64'(m_idx));
                        chk("acc_sample", 64'(sample_out), 64'(model_out(s, cur_med, cur_mad)));
                        chk("acc_flag", 64'(outlier_flag), 64'(f));
                        cap_flag[m_idx] = int'(outlier_flag);
                        cap_samp[m_idx] = int'(sample_out);
                        cap_idx[m_idx]  = int'(sample_idx);
                        m_cnt += f;
                        m_idx++;
                        if (m_idx == P) exp_done = 1;
                    end
                end
            end
            prev_stall = sample_vld && !out_rdy;
            ps = sample_out;
            pf = outlier_flag;
            pi = sample_idx;
        end
    end

    task automatic issue(input int m, input int mad);
        stats_vld    = 1'b1;
        local_median = 16'(m);
        MAD          = 16'(mad);
        if (busy) begin
            pend_med = m;
            pend_mad = mad;
            pend_v   = 1;
        end else begin
            cur_med = m;
            cur_mad = mad;
            busy    = 1;
            m_idx   = 0;
            m_cnt   = 0;
        end
        stats_cyc = cyc;
        @(negedge clk);
        stats_vld    = 1'b0;
        local_median = 16'($urandom);
        MAD          = 16'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || pend_v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || pend_v) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic load_mem(input int a, input int b, input int c, input int d);
        mem[0] = DW'(a);
        mem[1] = DW'(b);
        mem[2] = DW'(c);
        mem[3] = DW'(d);
    endtask

    task automatic chk_flags(input string name, input int a, input int b, input int c, input int d);
        chk({name, "_f0"}, 64'(cap_flag[0]), 64'(a));
        chk({name, "_f1"}, 64'(cap_flag[1]), 64'(b));
        chk({name, "_f2"}, 64'(cap_flag[2]), 64'(c));
        chk({name, "_f3"}, 64'(cap_flag[3]), 64'(d));
    endtask

    initial begin
        int d0;
        int n;
        rst_n        = 1'b0;
        stats_vld    = 1'b0;
        local_median = '0;
        MAD          = '0;
        load_mem(0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_rd_rqst", 64'(rd_rqst), 64'(0));
        chk("rst_sample_vld", 64'(sample_vld), 64'(0));
        chk("rst_flag", 64'(outlier_flag), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_addr", 64'(addr_out), 64'(0));
        chk("rst_idx", 64'(sample_idx), 64'(0));
        chk("rst_sample", 64'(sample_out), 64'(0));
        chk("rst_cnt", 64'(outlier_cnt), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pin the model with hand-computed points: thr(MAD=2) = 2*380*3 = 2280.
        chk("model_58", 64'(model_flag(58, 50, 2)), 64'(0));
        chk("model_59", 64'(model_flag(59, 50, 2)), 64'(1));
        chk("model_mad0_same", 64'(model_flag(50, 50, 0)), 64'(0));
        chk("model_mad0_one", 64'(model_flag(51, 50, 0)), 64'(1));

        // Basic window with tight memory and a free-running consumer.
        load_mem(50, 58, 59, 40);
        rq_armed = 1;
        d0 = done_seen;
        issue(50, 2);
        wait_idle(200);
        repeat (4) @(negedge clk);
        chk("t1_done_once", 64'(done_seen - d0), 64'(1));
        chk("t1_first_rq_lat", 64'(first_rq_cyc - stats_cyc), 64'(2));
        chk("t1_first_rq_addr", 64'(first_rq_addr), 64'(0));
        // stats_vld cycle and done cycle both counted: 2 + 3*P + 1 cycles.
        chk("t1_done_lat", 64'(done_cyc - stats_cyc), 64'(3 * P + 2));
        chk_flags("t1", 0, 0, 1, 1);
        chk("t1_cnt", 64'(outlier_cnt), 64'(2));
`ifdef HAMPEL_REPLACE_EN
        chk("t1_s0", 64'(cap_samp[0]), 64'(50));
        chk("t1_s1", 64'(cap_samp[1]), 64'(58));
        chk("t1_s2", 64'(cap_samp[2]), 64'(50));
        chk("t1_s3", 64'(cap_samp[3]), 64'(50));
`else
        chk("t1_s0", 64'(cap_samp[0]), 64'(50));
        chk("t1_s1", 64'(cap_samp[1]), 64'(58));
        chk("t1_s2", 64'(cap_samp[2]), 64'(59));
        chk("t1_s3", 64'(cap_samp[3]), 64'(40));
`endif

        // MAD = 0: any nonzero deviation is an outlier.
        load_mem(50, 51, 49, 50);
        issue(50, 0);
        wait_idle(200);
        @(negedge clk);
        chk_flags("t2", 0, 1, 1, 0);
        chk("t2_cnt", 64'(outlier_cnt), 64'(2));

        // Consumer stalls for 5 cycles on the first emitted sample.
        load_mem(50, 58, 59, 40);
        d0 = stall_checks;
        stall_left = 5;
        rdy_mode = 3;
        issue(50, 2);
        wait_idle(300);
        rdy_mode = 0;
        chk("t3_stall_cycles", 64'(stall_checks - d0), 64'(5));

        // Second stats mid-scan: first window unchanged, then a full rescan with median 10.
        d0 = done_seen;
        issue(50, 2);
        n = 0;
        while (m_idx < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_idx2", 64'(m_idx >= 2), 64'(1));
        issue(10, 2);
        n = 0;
        while (done_seen == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_flags("t4a", 0, 0, 1, 1);
        wait_idle(300);
        @(negedge clk);
        chk("t4_two_dones", 64'(done_seen - d0), 64'(2));
        chk_flags("t4b", 1, 1, 1, 1);
        chk("t4b_idx0", 64'(cap_idx[0]), 64'(0));
        chk("t4b_cnt", 64'(outlier_cnt), 64'(4));

        // Reset while waiting for read data at index 2; the late data_rdy must be ignored.
        lat = 3;
        issue(50, 2);
        n = 0;
        while (!(rd_rqst && addr_out == AW'(2)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_req2", 64'(rd_rqst && addr_out == AW'(2)), 64'(1));
        @(negedge clk);
        abort_mode = 1;
        rst_n = 1'b0;
        busy   = 0;
        pend_v = 0;
        m_idx  = 0;
        m_cnt  = 0;
        #1;
        chk("t5_rd_rqst", 64'(rd_rqst), 64'(0));
        chk("t5_vld", 64'(sample_vld), 64'(0));
        chk("t5_flag", 64'(outlier_flag), 64'(0));
        chk("t5_done", 64'(done), 64'(0));
        chk("t5_addr", 64'(addr_out), 64'(0));
        chk("t5_idx", 64'(sample_idx), 64'(0));
        chk("t5_sample", 64'(sample_out), 64'(0));
        chk("t5_cnt", 64'(outlier_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #3;
            chk("t5_no_vld", 64'(sample_vld), 64'(0));
            chk("t5_no_rqst", 64'(rd_rqst), 64'(0));
        end
        abort_mode = 0;
        lat = 1;

        // Randomized windows: random data, stats, memory latency, backpressure, stray data_rdy.
        spur_en = 1;
        for (int w = 0; w < 40; w++) begin
            lat      = $urandom_range(1, 3);
            rdy_mode = $urandom_range(0, 1);
            for (int i = 0; i < P; i++) mem[i] = DW'($urandom);
            issue($urandom_range(0, 255), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                issue($urandom_range(0, 255), $urandom_range(0, 6));
            end
            wait_idle(2000);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        spur_en  = 0;
        rdy_mode = 0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hampel_flagger.md
# hampel_flagger

Downstream stage of the median/MAD calculator. On each `stats_vld` pulse, latches the local median and MAD and builds a Hampel threshold `THRESH_K * SCALE_FACTOR * MAD` (Q8.8). It then re-reads the whole population window from the sample buffer and streams every sample out with an outlier flag. It also reports an outlier count per window.

## Interface
- `POPSIZE`, 100, samples per window.
- `DATA_WIDTH`, 8, unsigned sample width.
- `SCALE_FACTOR`, 'h017C, MAD-to-sigma factor, unsigned Q8.8, 16 bits.
- `THRESH_K`, 3, integer sigma multiplier, 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stats_vld`  in  1  one-cycle pulse; `local_median`/`MAD` valid.
- `local_median`  in  16  median, unsigned integer; low DATA_WIDTH bits used.
- `MAD`  in  16  unscaled MAD, unsigned integer.
- `rd_rqst`  out  1  one-cycle read request to sample buffer.
- `addr_out`  out  $clog2(POPSIZE)  read index.
- `data_in`  in  DATA_WIDTH  read data.
- `data_rdy`  in  1  read data valid; at least 1 cycle after `rd_rqst`.
- `sample_out`  out  DATA_WIDTH  emitted sample.
- `sample_idx`  out  $clog2(POPSIZE)  index of emitted sample.
- `outlier_flag`  out  1  sample is an outlier; qualified by `sample_vld`.
- `sample_vld`  out  1  output valid; held until `out_rdy`.
- `out_rdy`  in  1  consumer accepts when `sample_vld && out_rdy`.
- `done`  out  1  one-cycle pulse after the last sample is accepted.
- `outlier_cnt`  out  $clog2(POPSIZE+1)  outliers in last/current window.

## Operation
- FSM states:
  - IDLE: wait for `stats_vld` or a pending request.
  - LOAD: latch stats, compute threshold.
  - REQ: pulse `rd_rqst`.
  - WAIT: wait for `data_rdy`.
  - EMIT: hold `sample_vld` until `out_rdy`.
  - DONE: pulse `done`.
- Transitions:
  - IDLE → LOAD on `stats_vld` or pending request.
  - LOAD → REQ.
  - REQ → WAIT.
  - WAIT → EMIT on `data_rdy`.
  - EMIT → REQ on accept with index < POPSIZE-1.
  - EMIT → DONE on accept with index == POPSIZE-1.
  - DONE → IDLE.
- Entering LOAD: index and `outlier_cnt` cleared to 0.
- Arithmetic:
  - `thr` = MAD × SCALE_FACTOR × THRESH_K, 36-bit unsigned, Q8.8.
  - `dev` = |data_in − median[DATA_WIDTH-1:0]|, DATA_WIDTH bits.
  - Outlier iff `{dev, 8'b0}` > `thr`, strict compare.
  - No truncation anywhere.
- MAD = 0: any nonzero deviation is flagged; deviation 0 is never flagged.
- `outlier_cnt` increments on accept of a flagged sample. It holds its value after DONE until the next LOAD.
- `stats_vld` while not IDLE: latched into a one-deep pending register, with newer stats overwriting. The pending request starts a new scan immediately after DONE. No effect on the scan in progress.
- `data_rdy` outside WAIT is ignored.
- `out_rdy` outside EMIT is ignored.
- Reset values:
  - FSM IDLE, pending cleared.
  - `rd_rqst`, `sample_vld`, `outlier_flag`, `done` = 0.
  - `addr_out`, `sample_idx`, `sample_out`, `outlier_cnt` = 0.
- Reset mid-scan aborts immediately. Any in-flight read is dropped.

## Timing
- `stats_vld` at cycle 0 → LOAD at cycle 1 → `rd_rqst` at cycle 2 with `addr_out`=0.
- `addr_out` is stable from REQ until `data_rdy`.
- `sample_out`, `outlier_flag`, `sample_idx` and `sample_vld` are registered. They appear the cycle after `data_rdy` and stay stable while `sample_vld && !out_rdy`.
- Throughput with `data_rdy` one cycle after `rd_rqst` and `out_rdy` tied high: 3 cycles per sample.
- `done` is asserted the cycle after the final accept.
- Full window latency with that memory and `out_rdy` tied high: 2 + 3·POPSIZE + 1 cycles from `stats_vld` to `done`.

## Configuration
- `HAMPEL_REPLACE_EN` defined: a flagged sample is emitted with `sample_out` = median. `outlier_flag` is still asserted.
- Undefined: `sample_out` is always the raw `data_in`.

## Structure
- Shared package `madcalc_pkg` contains:
  - the FSM state enum;
  - `Q_FRAC_BITS` = 8;
  - default `SCALE_FACTOR` constant;
  - the threshold width constant (36).
- One sub-module, `hampel_thresh`: registered MAD × SCALE_FACTOR × THRESH_K multiplier. It is loaded in LOAD and its result is valid by REQ.

## Test plan
- POPSIZE=4, median=50, MAD=2, K=3 (thr=2280), samples 50,58,59,40 → flags 0,0,1,1; `outlier_cnt`=2; `done` pulses once.
- Same stimulus with `HAMPEL_REPLACE_EN` → `sample_out` 50,58,50,50.
- MAD=0, median=50, samples 50,51,49,50 → flags 0,1,1,0; `outlier_cnt`=2.
- `out_rdy` low for 5 cycles during EMIT → `sample_vld` and outputs stable; no new `rd_rqst` until accept.
- Second `stats_vld` mid-scan (median=10) → first window completes unchanged, then a second scan starts with index 0 and median 10.
- `rst_n` low during WAIT at index 2 → all outputs return to reset values. A late `data_rdy` is ignored and no `sample_vld` is produced.
